// File: rtl/dhms_pkg.sv
// Shared state codes, field limits and compare-based wrap helpers for the time-set controller.
package dhms_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RUN     = 3'd0;
    localparam state_t ST_SET_DAY = 3'd1;
    localparam state_t ST_SET_HR  = 3'd2;
    localparam state_t ST_SET_MIN = 3'd3;
    localparam state_t ST_SET_SEC = 3'd4;
    localparam state_t ST_AL_HR   = 3'd5;
    localparam state_t ST_AL_MIN  = 3'd6;

    localparam logic [5:0] HR_MAX  = 6'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] DAY_MIN = 6'd1;

    // Out-of-range values snap to lo on the first step in either direction.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v,
                                            input logic [5:0] lo,
                                            input logic [5:0] hi);
        if (v < lo || v >= hi)
            return lo;
        return v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v,
                                            input logic [5:0] lo,
                                            input logic [5:0] hi);
        if (v < lo || v > hi)
            return lo;
        if (v == lo)
            return hi;
        return v - 6'd1;
    endfunction

endpackage

// File: rtl/dhms_time_ctrl_btn_edge.sv
// Button press detector: one-cycle pulse in the cycle a level button first reads high.
// Latency: press is combinational from btn against the registered previous level.
// No backpressure: a held button yields exactly one pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prev <= 1'b0;
        else
            prev <= btn;
    end

    assign press = btn & ~prev;

endmodule

// File: rtl/dhms_time_ctrl.sv
// Time-set / alarm controller: stops the day/hr/min/sec counter while shadows are edited, then loads them.
// Latency: a press acts on the clock edge it is sampled; cnt_en, ld and alarm are registered (next cycle).
// No backpressure: each press performs one action; a press while alarm is active only silences it.
module dhms_time_ctrl
    import dhms_pkg::*;
#(
    parameter int DAYS_MAX    = 30,
    parameter int ALARM_SECS  = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic [4:0] cur_day,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       sec_tick,
    output logic       cnt_en,
    output logic       ld,
    output logic [4:0] ld_day,
    output logic [4:0] ld_hr,
    output logic [5:0] ld_min,
    output logic [5:0] ld_sec,
    output logic [2:0] edit_field,
    output logic       alarm
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int AC_W = $clog2(ALARM_SECS + 1);

    logic p_mode, p_up, p_dn;

    btn_edge u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .press(p_mode));
    btn_edge u_up   (.clk(clk), .rst(rst), .btn(btn_up),   .press(p_up));
    btn_edge u_dn   (.clk(clk), .rst(rst), .btn(btn_dn),   .press(p_dn));

    state_t            state, nxt_state;
    logic [4:0]        al_hr;
    logic [5:0]        al_min;
    logic              armed;
    logic [TO_W-1:0]   to_cnt;
    logic [AC_W-1:0]   al_cnt;
    logic              match_q;

    logic any_press, consume, act_mode, act_up, act_dn;
    logic timeout, enter_set, match, al_fire, fld_chg, nxt_is_set;
    logic [5:0] fld_val, fld_lo, fld_hi, fld_new;

    assign any_press = p_mode | p_up | p_dn;
    assign consume   = alarm & any_press;
    assign act_mode  = p_mode & ~consume;
    assign act_up    = p_up & ~p_dn & ~p_mode & ~consume;
    assign act_dn    = p_dn & ~p_up & ~p_mode & ~consume;
    assign fld_chg   = act_up | act_dn;

    assign timeout   = (state != ST_RUN) && !any_press &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign enter_set = (state == ST_RUN) && act_mode;

    assign match   = armed && ({cur_hr, cur_min, cur_sec} == {al_hr, al_min, 6'd0});
    assign al_fire = match && !match_q && cnt_en;

    // One shared inc/dec path serves whichever field the current state edits.
    always_comb begin
        fld_val = 6'd0;
        fld_lo  = 6'd0;
        fld_hi  = 6'd0;
        case (state)
            ST_SET_DAY: begin fld_val = {1'b0, ld_day}; fld_lo = DAY_MIN; fld_hi = 6'(DAYS_MAX); end
            ST_SET_HR:  begin fld_val = {1'b0, ld_hr};  fld_hi = HR_MAX;  end
            ST_SET_MIN: begin fld_val = ld_min;         fld_hi = MIN_MAX; end
            ST_SET_SEC: begin fld_val = ld_sec;         fld_hi = SEC_MAX; end
            ST_AL_HR:   begin fld_val = {1'b0, al_hr};  fld_hi = HR_MAX;  end
            ST_AL_MIN:  begin fld_val = al_min;         fld_hi = MIN_MAX; end
            default:    begin fld_val = 6'd0; end
        endcase
        fld_new = act_up ? wrap_inc(fld_val, fld_lo, fld_hi)
                         : wrap_dec(fld_val, fld_lo, fld_hi);
    end

    always_comb begin
        nxt_state = state;
        if (timeout) begin
            nxt_state = ST_RUN;
        end else if (act_mode) begin
            case (state)
                ST_RUN:     nxt_state = ST_SET_DAY;
                ST_SET_DAY: nxt_state = ST_SET_HR;
                ST_SET_HR:  nxt_state = ST_SET_MIN;
                ST_SET_MIN: nxt_state = ST_SET_SEC;
                ST_SET_SEC: nxt_state = ST_AL_HR;
                ST_AL_HR:   nxt_state = ST_AL_MIN;
                default:    nxt_state = ST_RUN;
            endcase
        end
        nxt_is_set = (nxt_state >= ST_SET_DAY) && (nxt_state <= ST_SET_SEC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            cnt_en <= 1'b1;
            ld     <= 1'b0;
            ld_day <= 5'd1;
            ld_hr  <= 5'd0;
            ld_min <= 6'd0;
            ld_sec <= 6'd0;
            al_hr  <= 5'd0;
            al_min <= 6'd0;
            armed  <= 1'b0;
            to_cnt <= '0;
        end else begin
            state  <= nxt_state;
            cnt_en <= !nxt_is_set;
            ld     <= (state == ST_SET_SEC) && act_mode;

            if (enter_set) begin
                ld_day <= cur_day;
                ld_hr  <= cur_hr;
                ld_min <= cur_min;
                ld_sec <= cur_sec;
            end else if (fld_chg) begin
                case (state)
                    ST_SET_DAY: ld_day <= fld_new[4:0];
                    ST_SET_HR:  ld_hr  <= fld_new[4:0];
                    ST_SET_MIN: ld_min <= fld_new;
                    ST_SET_SEC: ld_sec <= fld_new;
                    ST_AL_HR:   al_hr  <= fld_new[4:0];
                    ST_AL_MIN:  al_min <= fld_new;
                    default:    ;
                endcase
            end

            if ((state == ST_AL_MIN) && act_mode)
                armed <= 1'b1;

            if ((state == ST_RUN) || any_press || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Alarm duration is measured in sec_tick pulses seen after the alarm rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm   <= 1'b0;
            al_cnt  <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= match;
            if (enter_set) begin
                alarm <= 1'b0;
            end else if (al_fire) begin
                alarm  <= 1'b1;
                al_cnt <= '0;
            end else if (alarm) begin
                if (any_press) begin
                    alarm <= 1'b0;
                end else if (sec_tick) begin
                    if (al_cnt == AC_W'(ALARM_SECS - 1))
                        alarm <= 1'b0;
                    al_cnt <= al_cnt + AC_W'(1);
                end
            end
        end
    end

    assign edit_field = state;

endmodule

// File: tb/tb_dhms_time_ctrl.sv
// Bench for dhms_time_ctrl: directed steps plus randomized edit sessions checked against a modular-arithmetic model.
module tb_dhms_time_ctrl;

    localparam int DAYS  = 30;
    localparam int ASECS = 10;
    localparam int TO    = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_dn = 1'b0;
    logic [4:0] cur_day = 5'd1, cur_hr = 5'd0;
    logic [5:0] cur_min = 6'd0, cur_sec = 6'd1;
    logic       sec_tick = 1'b0;
    logic       cnt_en, ld, alarm;
    logic [4:0] ld_day, ld_hr;
    logic [5:0] ld_min, ld_sec;
    logic [2:0] edit_field;

    always #5 clk = ~clk;

    dhms_time_ctrl #(.DAYS_MAX(DAYS), .ALARM_SECS(ASECS), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_dn(btn_dn),
        .cur_day(cur_day), .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
        .sec_tick(sec_tick),
        .cnt_en(cnt_en), .ld(ld),
        .ld_day(ld_day), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
        .edit_field(edit_field), .alarm(alarm)
    );

    int tests = 0;
    int fails = 0;
    int ld_cnt = 0;
    int cap_day, cap_hr, cap_min, cap_sec;
    logic cap_en;
    logic [2:0] cap_ef;

    // Every ld pulse is logged with the values presented alongside it.
    always @(negedge clk) begin
        if (ld === 1'b1) begin
            ld_cnt  <= ld_cnt + 1;
            cap_day <= int'(ld_day);
            cap_hr  <= int'(ld_hr);
            cap_min <= int'(ld_min);
            cap_sec <= int'(ld_sec);
            cap_en  <= cnt_en;
            cap_ef  <= edit_field;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int m_day, m_hr, m_min, m_sec, m_ah, m_am;

    function automatic int wstep(input int v, input int lo, input int hi, input int d);
        int n;
        n = hi - lo + 1;
        return lo + (((v - lo + d) % n) + n) % n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        @(negedge clk);
        btn_mode = m; btn_up = u; btn_dn = d;
        @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        #1;
    endtask

    task automatic set_cur(input int d, input int h, input int m, input int s);
        cur_day = 5'(d); cur_hr = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task automatic rand_adjust(inout int v, input int lo, input int hi);
        int k;
        k = $urandom_range(0, 5);
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                press(1'b0, 1'b1, 1'b0);
                v = wstep(v, lo, hi, 1);
            end else begin
                press(1'b0, 1'b0, 1'b1);
                v = wstep(v, lo, hi, -1);
            end
        end
    endtask

    initial begin
        int base;
        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk("rst_cnt_en", cnt_en, 1);
        chk("rst_edit_field", edit_field, 0);
        chk("rst_ld", ld, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_ld_day", ld_day, 1);
        idle(3);
        set_cur(5, 10, 20, 30);
        @(negedge clk) rst = 1'b1;
        idle(20);
        chk("idle_cnt_en", cnt_en, 1);
        chk("idle_ld", ld, 0);
        chk("idle_alarm", alarm, 0);
        chk("idle_edit_field", edit_field, 0);
        chk("idle_ld_day", ld_day, 1);
        m_ah = 0; m_am = 0;

        // Edit and load.
        press(1'b1, 1'b0, 1'b0);
        chk("edit_ef", edit_field, 1);
        chk("edit_cnt_en", cnt_en, 0);
        chk("copy_day", ld_day, 5);
        chk("copy_hr", ld_hr, 10);
        chk("copy_min", ld_min, 20);
        chk("copy_sec", ld_sec, 30);
        m_day = 5;
        for (int i = 0; i < 26; i++) begin
            press(1'b0, 1'b1, 1'b0);
            m_day = wstep(m_day, 1, DAYS, 1);
        end
        chk("day_wrap_up", ld_day, m_day);
        chk("day_wrap_const", ld_day, 1);
        base = ld_cnt;
        press(1'b1, 1'b0, 1'b0);
        chk("ef_hr", edit_field, 2);
        press(1'b1, 1'b0, 1'b0);
        chk("ef_min", edit_field, 3);
        press(1'b1, 1'b0, 1'b0);
        chk("ef_sec", edit_field, 4);
        chk("sec_cnt_en", cnt_en, 0);
        chk("no_early_ld", ld_cnt, base);
        press(1'b1, 1'b0, 1'b0);
        idle(2);
        chk("ld_pulses", ld_cnt, base + 1);
        chk("ld_val_day", cap_day, 1);
        chk("ld_val_hr", cap_hr, 10);
        chk("ld_val_min", cap_min, 20);
        chk("ld_val_sec", cap_sec, 30);
        chk("ld_cnt_en", cap_en, 1);
        chk("ld_ef", cap_ef, 5);
        chk("ld_low_after", ld, 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("back_run_ef", edit_field, 0);
        chk("back_run_en", cnt_en, 1);

        // Wraps and button conflicts.
        set_cur(3, 0, 59, 1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("hr_wrap_dn", ld_hr, 23);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("min_wrap_up", ld_min, 0);
        press(1'b0, 1'b1, 1'b1);
        chk("updn_min", ld_min, 0);
        chk("updn_ef", edit_field, 3);
        press(1'b1, 1'b1, 1'b0);
        chk("modeup_ef", edit_field, 4);
        chk("modeup_min", ld_min, 0);
        chk("modeup_sec", ld_sec, 1);
        base = ld_cnt;
        press(1'b1, 1'b0, 1'b0);
        idle(1);
        chk("ld2_pulses", ld_cnt, base + 1);
        chk("ld2_day", cap_day, 3);
        chk("ld2_hr", cap_hr, 23);

        // Alarm at 07:30.
        for (int i = 0; i < 7; i++) begin
            press(1'b0, 1'b1, 1'b0);
            m_ah = wstep(m_ah, 0, 23, 1);
        end
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            press(1'b0, 1'b1, 1'b0);
            m_am = wstep(m_am, 0, 59, 1);
        end
        press(1'b1, 1'b0, 1'b0);
        chk("al_set_ef", edit_field, 0);
        set_cur(3, 7, 29, 59);
        idle(2);
        chk("al_before", alarm, 0);
        set_cur(3, 7, 30, 0);
        idle(1);
        chk("al_fire", alarm, 1);
        for (int i = 0; i < ASECS - 1; i++) tick();
        chk("al_hold", alarm, 1);
        tick();
        chk("al_expire", alarm, 0);
        set_cur(3, 7, 30, 1);
        idle(2);
        set_cur(3, 7, 30, 0);
        idle(1);
        chk("al_refire", alarm, 1);
        base = ld_cnt;
        press(1'b0, 1'b1, 1'b0);
        chk("al_silence", alarm, 0);
        chk("al_silence_ef", edit_field, 0);
        chk("al_silence_en", cnt_en, 1);
        chk("al_silence_day", ld_day, 3);
        idle(2);
        chk("al_silence_ld", ld_cnt, base);

        // Randomized edit sessions against the model.
        for (int it = 0; it < 3; it++) begin
            m_day = $urandom_range(1, DAYS);
            m_hr  = $urandom_range(0, 23);
            m_min = $urandom_range(0, 59);
            m_sec = $urandom_range(1, 59);
            set_cur(m_day, m_hr, m_min, m_sec);
            idle(2);
            press(1'b1, 1'b0, 1'b0);
            chk("r_copy_day", ld_day, m_day);
            rand_adjust(m_day, 1, DAYS);
            chk("r_day", ld_day, m_day);
            press(1'b1, 1'b0, 1'b0);
            rand_adjust(m_hr, 0, 23);
            chk("r_hr", ld_hr, m_hr);
            press(1'b1, 1'b0, 1'b0);
            rand_adjust(m_min, 0, 59);
            chk("r_min", ld_min, m_min);
            press(1'b1, 1'b0, 1'b0);
            rand_adjust(m_sec, 0, 59);
            chk("r_sec", ld_sec, m_sec);
            base = ld_cnt;
            press(1'b1, 1'b0, 1'b0);
            idle(1);
            chk("r_ld_pulses", ld_cnt, base + 1);
            chk("r_ld_val", {cap_day[7:0], cap_hr[7:0], cap_min[7:0], cap_sec[7:0]},
                {m_day[7:0], m_hr[7:0], m_min[7:0], m_sec[7:0]});
            chk("r_ld_en", cap_en, 1);
            rand_adjust(m_ah, 0, 23);
            press(1'b1, 1'b0, 1'b0);
            rand_adjust(m_am, 0, 59);
            press(1'b1, 1'b0, 1'b0);
            chk("r_run_ef", edit_field, 0);
            set_cur(1, m_ah, m_am, 1);
            idle(2);
            chk("r_al_quiet", alarm, 0);
            set_cur(1, m_ah, m_am, 0);
            idle(1);
            chk("r_al_fire", alarm, 1);
            press(1'b0, 1'b0, 1'b1);
            chk("r_al_clear", alarm, 0);
        end

        // Timeout from SET_DAY with an out-of-range copied day.
        set_cur(31, 5, 5, 5);
        idle(2);
        press(1'b1, 1'b0, 1'b0);
        chk("oor_copy", ld_day, 31);
        press(1'b0, 1'b1, 1'b0);
        chk("oor_up_min", ld_day, 1);
        press(1'b0, 1'b1, 1'b0);
        chk("oor_up2", ld_day, 2);
        base = ld_cnt;
        idle(TO - 1);
        chk("to_not_yet", edit_field, 1);
        idle(1);
        chk("to_ef", edit_field, 0);
        chk("to_cnt_en", cnt_en, 1);
        chk("to_no_ld", ld_cnt, base);

        // Reset in the middle of an edit.
        set_cur(4, 4, 4, 4);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("mid_ef", edit_field, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_en", cnt_en, 1);
        chk("mid_rst_ef", edit_field, 0);
        chk("mid_rst_min", ld_min, 0);
        chk("mid_rst_day", ld_day, 1);
        chk("mid_rst_ld", ld, 0);
        @(negedge clk) rst = 1'b1;
        set_cur(1, 0, 0, 5);
        idle(2);
        set_cur(1, 0, 0, 0);
        idle(2);
        chk("mid_rst_disarmed", alarm, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dhms_time_ctrl.md
Name: dhms_time_ctrl

Overview:
Time-set and alarm controller for the day/hr/min/sec timekeeping counter. Decodes three push-buttons into a mode FSM. Stops the counter while the user edits shadow copies of day/hr/min/sec, then loads them back with a one-cycle strobe. Holds an alarm time (hr:min) and raises a timed alarm output when the running time matches it.

Parameters:
DAYS_MAX, 30, last day of month; day field wraps DAYS_MAX->1 and 1->DAYS_MAX.
ALARM_SECS, 10, alarm duration in sec_tick pulses.
TIMEOUT_CYC, 1000, idle clock cycles in any edit state before auto-return to RUN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
btn_mode  in  1  mode button, level, already synchronised to clk.
btn_up  in  1  increment button, level, synchronised.
btn_dn  in  1  decrement button, level, synchronised.
cur_day  in  5  counter day, 1..DAYS_MAX.
cur_hr  in  5  counter hour, 0..23.
cur_min  in  6  counter minute, 0..59.
cur_sec  in  6  counter second, 0..59.
sec_tick  in  1  one-cycle pulse when the counter's second advances.
cnt_en  out  1  counter count enable (registered).
ld  out  1  one-cycle counter load strobe; ld has priority over count in the counter.
ld_day  out  5  shadow day, load value.
ld_hr  out  5  shadow hour.
ld_min  out  6  shadow minute.
ld_sec  out  6  shadow second.
edit_field  out  3  current state code, for display blinking.
alarm  out  1  alarm active.

Behaviour:
- Reset (rst=0, async) forces:
  - state RUN; cnt_en=1; ld=0; alarm=0; edit_field=0.
  - ld_day=1; ld_hr=ld_min=ld_sec=0.
  - al_hr=0, al_min=0, armed=0; timeout and alarm counters 0.
- Button handling:
  - Each button is registered; press = rising edge (prev 0, now 1). Exactly one action per press.
  - up and dn pressed in the same cycle: both ignored.
  - mode together with up or dn: mode acts, up/dn ignored.
- States and codes: RUN=0, SET_DAY=1, SET_HR=2, SET_MIN=3, SET_SEC=4, AL_HR=5, AL_MIN=6. edit_field = state code.
- RUN:
  - cnt_en=1.
  - mode press -> SET_DAY. On the same edge, copy cur_* into the shadows. cnt_en=0 from the next cycle.
- SET_DAY/SET_HR/SET_MIN/SET_SEC:
  - cnt_en=0. up/dn changes only the selected shadow field, with wrap: day 1..DAYS_MAX, hr 0..23, min/sec 0..59.
  - mode steps SET_DAY->SET_HR->SET_MIN->SET_SEC.
  - mode in SET_SEC -> AL_HR. On that edge, ld=1 for exactly one cycle and cnt_en=1 in the same cycle.
- AL_HR/AL_MIN:
  - cnt_en=1. up/dn changes al_hr (0..23) or al_min (0..59), with wrap.
  - mode in AL_HR -> AL_MIN. mode in AL_MIN -> RUN and sets armed=1.
- Timeout:
  - Counter runs in every non-RUN state and clears on any press.
  - On reaching TIMEOUT_CYC: go to RUN, cnt_en=1.
  - A timeout from a SET_* state discards the shadows (no ld pulse). A timeout from an AL_* state keeps the alarm edits but does not change armed.
- Alarm:
  - match = armed && {cur_hr,cur_min,cur_sec}=={al_hr,al_min,0}.
  - Rising edge of match (registered previous value) sets alarm=1 on the next cycle. This fires once per matching second, in any state where the counter runs.
  - alarm clears after ALARM_SECS sec_tick pulses, counted from assertion.
  - alarm also clears on any button press. That press is consumed: no FSM action.
  - Entering a SET_* state clears alarm.
- Width rules:
  - All field arithmetic is done at field width; wrap is by compare, never modulo.
  - Out-of-range cur_* values are copied unchanged. The first up/dn on such a field wraps it to its minimum.

Decomposition:
- Package dhms_pkg:
  - state enum/codes;
  - HR_MAX=23, MIN_MAX=59, SEC_MAX=59, DAY_MIN=1;
  - wrap_inc/wrap_dec functions parameterised by min/max.
- One sub-module, btn_edge: register plus rising-edge pulse, instantiated three times.

Test Plan:
- Reset, release, idle 20 cycles -> cnt_en=1, ld=0, alarm=0, edit_field=0, ld_day=1.
- Edit and load:
  - cur=(5,10:20:30); mode -> edit_field=1, cnt_en=0, ld_*=(5,10,20,30).
  - 26 up presses -> ld_day=1 (wrap at 31).
  - mode x4 -> single ld pulse with (1,10,20,30), cnt_en=1 in the same cycle, edit_field=5.
- Wrap and conflicts:
  - SET_HR at 0, dn -> 23.
  - SET_MIN at 59, up -> 0.
  - up+dn in the same cycle -> no change.
  - mode+up together -> state advances, field unchanged.
- Alarm:
  - Set 07:30, exit to RUN, drive cur 07:29:59 then 07:30:00 -> alarm=1 one cycle later.
  - Stays high for 10 sec_ticks, then 0.
  - Repeat; press up while alarm=1 -> alarm=0, edit_field stays 0, nothing modified.
- Timeout: enter SET_DAY, press up twice, then idle TIMEOUT_CYC cycles -> edit_field=0, cnt_en=1, ld never asserted.
- Reset mid-edit: rst=0 while in SET_MIN -> outputs immediately go to reset values (cnt_en=1, edit_field=0, ld_min=0, armed=0).
